// File: rtl/test_vector_sequencer_pkg.sv
// ------------------------------------------------------------------
// test_vector_sequencer_pkg : shared state encoding, default widths and entry packing
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package test_vector_sequencer_pkg;

  localparam int STIM_W_DEF = 42;
  localparam int EXP_W_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_APPLY     = 3'd2,
    S_CHECK     = 3'd3,
    S_WAIT_STEP = 3'd4,
    S_DONE      = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  // Memory word layout is {stim, exp, mask}, mask in the least-significant bits.
  function automatic logic [STIM_W_DEF+2*EXP_W_DEF-1:0] pack_entry(
    input logic [STIM_W_DEF-1:0] stim,
    input logic [EXP_W_DEF-1:0]  exp_v,
    input logic [EXP_W_DEF-1:0]  mask
  );
    return {stim, exp_v, mask};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tvs_vector_ram.sv
// ------------------------------------------------------------------
// tvs_vector_ram : single-port synchronous RAM holding packed test vectors
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tvs_vector_ram #(
  parameter int WIDTH  = 58,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    if (re) rdata <= r_mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/test_vector_sequencer.sv
// ------------------------------------------------------------------
// test_vector_sequencer : drives stored stimulus, masked-compares the observed bus
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module test_vector_sequencer
  import test_vector_sequencer_pkg::*;
#(
  parameter int STIM_W   = STIM_W_DEF,
  parameter int EXP_W    = EXP_W_DEF,
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int SETTLE   = 1,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [STIM_W-1:0]   load_stim,
  input  logic [EXP_W-1:0]    load_exp,
  input  logic [EXP_W-1:0]    load_mask,
  input  logic [ADDR_W:0]     vec_count,
  input  logic                start,
  input  logic                step_mode,
  input  logic                step,
  input  logic                stop_on_err,
  input  logic                abort,
  input  logic [EXP_W-1:0]    observed,
  output logic [STIM_W-1:0]   stim_out,
  output logic                stim_valid,
  output logic                busy,
  output logic                done,
  output logic                err_halt,
  output logic [ADDR_W:0]     vector_num,
  output logic [ERRCNT_W-1:0] error_count,
  output logic                first_err_valid,
  output logic [ADDR_W-1:0]   first_err_idx
);

  localparam int                 ENTRY_W     = STIM_W + 2*EXP_W;
  localparam int                 SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [ADDR_W:0]    DEPTH_V     = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  logic [ADDR_W:0]     r_count;
  logic [SET_W-1:0]    r_settle_cnt;
  logic [EXP_W-1:0]    r_exp;
  logic [EXP_W-1:0]    r_mask;

  logic                w_we;
  logic                w_re;
  logic [ADDR_W-1:0]   w_addr;
  logic [ENTRY_W-1:0]  w_wdata;
  logic [ENTRY_W-1:0]  w_rdata;
  logic                w_mismatch;
  logic [ADDR_W:0]     w_count_clamped;
  logic                w_last;

  // Loads are only accepted while no run owns the RAM port.
  assign w_we    = load_en && (r_state == S_IDLE || r_state == S_DONE || r_state == S_HALT);
  assign w_re    = (r_state == S_FETCH);
  assign w_addr  = w_we ? load_addr : vector_num[ADDR_W-1:0];
  assign w_wdata = {load_stim, load_exp, load_mask};

  assign w_mismatch      = |((observed ^ r_exp) & r_mask);
  assign w_count_clamped = (vec_count > DEPTH_V) ? DEPTH_V : vec_count;
  assign w_last          = ((vector_num + 1'b1) == r_count);

  tvs_vector_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .re    (w_re),
    .addr  (w_addr),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_count         <= '0;
      r_settle_cnt    <= '0;
      r_exp           <= '0;
      r_mask          <= '0;
      stim_out        <= '0;
      stim_valid      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_halt        <= 1'b0;
      vector_num      <= '0;
      error_count     <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (abort && busy) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      busy         <= 1'b0;
      stim_valid   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_HALT: begin
          if (start) begin
            r_count         <= w_count_clamped;
            error_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            vector_num      <= '0;
            err_halt        <= 1'b0;
            stim_valid      <= 1'b0;
            if (vec_count == '0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= S_FETCH;
              done    <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_state      <= S_APPLY;
          r_settle_cnt <= '0;
        end
        S_APPLY: begin
          // RAM data lands one cycle after FETCH; the settle window starts here.
          if (r_settle_cnt == '0) begin
            stim_out   <= w_rdata[ENTRY_W-1 -: STIM_W];
            r_exp      <= w_rdata[2*EXP_W-1 -: EXP_W];
            r_mask     <= w_rdata[EXP_W-1:0];
            stim_valid <= 1'b1;
          end
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state      <= S_CHECK;
            r_settle_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (~&error_count) error_count <= error_count + 1'b1;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= vector_num[ADDR_W-1:0];
            end
          end
          if (w_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (stop_on_err && w_mismatch) begin
            r_state  <= S_HALT;
            busy     <= 1'b0;
            err_halt <= 1'b1;
          end else begin
            r_state    <= step_mode ? S_WAIT_STEP : S_FETCH;
            vector_num <= vector_num + 1'b1;
          end
        end
        S_WAIT_STEP: begin
          if (step) r_state <= S_FETCH;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_test_vector_sequencer.sv
// ------------------------------------------------------------------
// tb_test_vector_sequencer : directed vectors with a run-result scoreboard
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_test_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [41:0] load_stim;
  logic [7:0]  load_exp;
  logic [7:0]  load_mask;
  logic [4:0]  vec_count;
  logic        start, step_mode, step, stop_on_err, abort;
  logic [7:0]  observed;
  logic [41:0] stim_out;
  logic        stim_valid, busy, done, err_halt;
  logic [4:0]  vector_num;
  logic [1:0]  error_count;
  logic        first_err_valid;
  logic [3:0]  first_err_idx;

  test_vector_sequencer #(
    .STIM_W(42), .EXP_W(8), .DEPTH(16), .ADDR_W(4), .SETTLE(1), .ERRCNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask),
    .vec_count(vec_count), .start(start), .step_mode(step_mode), .step(step),
    .stop_on_err(stop_on_err), .abort(abort), .observed(observed),
    .stim_out(stim_out), .stim_valid(stim_valid), .busy(busy), .done(done),
    .err_halt(err_halt), .vector_num(vector_num), .error_count(error_count),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
  );

  // The device under test simply echoes the low stimulus byte.
  assign observed = stim_out[7:0];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t_start = 0;

  typedef struct {
    logic        done;
    logic        halt;
    int          vn;
    int          err;
    logic        fev;
    int          fidx;
    logic [41:0] stim;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  localparam logic [41:0] S0 = 42'h155_0000_0005;
  localparam logic [41:0] S1 = 42'h2AA_1234_560A;
  localparam logic [41:0] S2 = 42'h0F0_F0F0_F000;
  localparam logic [41:0] S4 = 42'h1C0_0000_003F;
  localparam logic [41:0] SB = 42'h100_0000_0000;

  function automatic void chk(input string name, input longint unsigned act, input longint unsigned expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  function automatic void push(input logic d, input logic h, input int vn, input int err,
                               input logic fev, input int fidx, input logic [41:0] s, input int cy);
    exp_t e;
    e.done = d; e.halt = h; e.vn = vn; e.err = err;
    e.fev = fev; e.fidx = fidx; e.stim = s; e.cycles = cy;
    sb.push_back(e);
  endfunction

  // Monitor: every run that finishes (Done or Err_Halt rising) retires one scoreboard entry.
  initial begin
    logic prev_end;
    logic cur_end;
    exp_t e;
    prev_end = 1'b0;
    forever begin
      @(negedge clk);
      cur_end = done | err_halt;
      if (cur_end && !prev_end) begin
        if (sb.size() == 0) begin
          chk("unexpected_run_end", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done", done, e.done);
          chk("err_halt", err_halt, e.halt);
          chk("busy_end", busy, 0);
          chk("vector_num", vector_num, e.vn);
          chk("error_count", error_count, e.err);
          chk("first_err_valid", first_err_valid, e.fev);
          if (e.fev) chk("first_err_idx", first_err_idx, e.fidx);
          chk("stim_out_hold", stim_out, e.stim);
          chk("stim_valid_hold", stim_valid, 1);
          if (e.cycles != 0) chk("latency", cyc - t_start, e.cycles);
        end
      end
      prev_end = cur_end;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [41:0] s, input logic [7:0] e, input logic [7:0] m);
    logic [31:0] av;
    av = a;
    load_en = 1'b1; load_addr = av[3:0]; load_stim = s; load_exp = e; load_mask = m;
    tick(1);
    load_en = 1'b0;
  endtask

  task automatic start_run(input int n);
    logic [31:0] nv;
    nv = n;
    vec_count = nv[4:0];
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_sb(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      $display("FAIL %s_timeout: got pending=%0d expected pending=0", name, sb.size());
      checks++;
      errors++;
      sb.delete();
    end
    tick(1);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_stim = '0; load_exp = '0; load_mask = '0;
    vec_count = '0; start = 1'b0; step_mode = 1'b0; step = 1'b0; stop_on_err = 1'b0; abort = 1'b0;
    tick(3);

    chk("rst_stim_out", stim_out, 0);
    chk("rst_stim_valid", stim_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_halt", err_halt, 0);
    chk("rst_vector_num", vector_num, 0);
    chk("rst_error_count", error_count, 0);
    chk("rst_first_err_valid", first_err_valid, 0);
    chk("rst_first_err_idx", first_err_idx, 0);
    rst = 1'b0;
    tick(1);

    // Three vectors, last one mismatches (exp FF vs observed 00).
    load(0, S0, 8'h05, 8'hFF);
    load(1, S1, 8'h0A, 8'hFF);
    load(2, S2, 8'hFF, 8'hFF);
    push(1, 0, 2, 1, 1, 2, S2, 9);
    start_run(3);
    wait_sb("basic");

    // Stop on error at vector 1; vector 2 never reaches Stim_Out.
    load(1, S1, 8'h0B, 8'hFF);
    stop_on_err = 1'b1;
    push(0, 1, 1, 1, 1, 1, S1, 6);
    start_run(3);
    wait_sb("stop_on_err");
    stop_on_err = 1'b0;

    // Abort during APPLY of vector 1 with a load attempted mid-run.
    load(1, S1, 8'h0A, 8'hFF);
    load(0, S0, 8'h06, 8'hFF);
    start_run(3);
    tick(1);
    load_en = 1'b1; load_addr = 4'd1; load_stim = 42'h000_0000_0077; load_exp = 8'h55; load_mask = 8'hFF;
    tick(1);
    load_en = 1'b0;
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_stim_valid", stim_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_error_count", error_count, 1);
    chk("abort_first_err_valid", first_err_valid, 1);
    chk("abort_vector_num", vector_num, 1);

    // Restart: counters clear; vector 1 must still be the original entry.
    push(1, 0, 2, 2, 1, 0, S2, 9);
    start_run(3);
    chk("restart_error_count", error_count, 0);
    chk("restart_first_err_valid", first_err_valid, 0);
    wait_sb("restart");

    // Single-step: Step during APPLY is ignored, one Step in WAIT_STEP finishes.
    load(0, S0, 8'h05, 8'hFF);
    step_mode = 1'b1;
    push(1, 0, 1, 0, 0, 0, S1, 0);
    start_run(2);
    tick(1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(6);
    chk("step_parked_busy", busy, 1);
    chk("step_parked_done", done, 0);
    chk("step_parked_vector_num", vector_num, 1);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    wait_sb("step");
    step_mode = 1'b0;

    // Partial mask: only the high nibble is compared.
    load(0, S4, 8'h30, 8'hF0);
    push(1, 0, 0, 0, 0, 0, S4, 3);
    start_run(1);
    wait_sb("mask");

    // Zero-length run completes immediately without a current vector.
    start_run(0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_stim_valid", stim_valid, 0);
    chk("zero_vector_num", vector_num, 0);
    tick(2);
    chk("zero_done_hold", done, 1);

    // Vec_Count beyond DEPTH clamps to 16 vectors.
    for (int i = 0; i < 16; i++) load(i, SB | 42'(i), 8'(i), 8'hFF);
    push(1, 0, 15, 0, 0, 0, SB | 42'd15, 48);
    start_run(31);
    wait_sb("clamp");

    // Five mismatches into a 2-bit counter saturate at 3.
    for (int i = 0; i < 5; i++) load(i, SB | 42'(i), 8'hFF, 8'hFF);
    push(1, 0, 4, 3, 1, 0, SB | 42'd4, 15);
    start_run(5);
    wait_sb("saturate");

    // Asynchronous reset while vector 0 is in CHECK.
    load(0, 42'h3FF_FFFF_FF00, 8'hFF, 8'hFF);
    start_run(3);
    tick(2);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_stim_valid", stim_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_stim_out", stim_out, 0);
    chk("async_stim_valid", stim_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_err_halt", err_halt, 0);
    chk("async_vector_num", vector_num, 0);
    chk("async_error_count", error_count, 0);
    chk("async_first_err_valid", first_err_valid, 0);
    tick(1);
    rst = 1'b0;
    tick(2);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/test_vector_sequencer.md
Name: test_vector_sequencer

Overview:
- Synthesizable successor to the testbench vector loop: stores stimulus/expected/mask vectors and drives the stimulus word to the device under test (e.g. the ALU system control inputs).
- Samples an observed bus, compares it under a per-bit mask, and counts mismatches.
- Adds behaviour the plain loop lacks: parametrised widths and depth, explicit vector count, settle delay, single-step mode, stop-on-error, first-error capture, and abort.

Parameters:
- STIM_W, 42, stimulus word width (matches the current control vector).
- EXP_W, 8, observed/expected/mask width.
- DEPTH, 1024, vector memory entries.
- ADDR_W, $clog2(DEPTH), memory index width.
- SETTLE, 1, cycles (≥1) between stimulus update and observed sample.
- ERRCNT_W, 16, error counter width.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Load_En  in  1  write one vector entry.
- Load_Addr  in  ADDR_W  entry index.
- Load_Stim  in  STIM_W  stimulus word.
- Load_Exp  in  EXP_W  expected value.
- Load_Mask  in  EXP_W  compare mask (1 = bit checked).
- Vec_Count  in  ADDR_W+1  vectors to run; latched at Start.
- Start  in  1  begin run (pulse).
- Step_Mode  in  1  1 = wait for Step after each vector.
- Step  in  1  advance one vector in step mode (pulse).
- Stop_On_Err  in  1  halt on first mismatch.
- Abort  in  1  return to IDLE.
- Observed  in  EXP_W  DUT result bus.
- Stim_Out  out  STIM_W  stimulus to DUT (registered).
- Stim_Valid  out  1  Stim_Out holds a current vector.
- Busy  out  1  run in progress.
- Done  out  1  all vectors applied.
- Err_Halt  out  1  stopped on mismatch.
- Vector_Num  out  ADDR_W+1  index of current/last vector.
- Error_Count  out  ERRCNT_W  mismatches, saturating.
- First_Err_Valid  out  1  a mismatch was captured.
- First_Err_Idx  out  ADDR_W  index of first mismatch.

Behaviour:
- Reset (async): state IDLE; all outputs 0 including Stim_Out. Memory contents are not reset.
- States: IDLE, FETCH, APPLY, CHECK, WAIT_STEP, DONE, HALT.
- Memory:
  - Synchronous write when Load_En and state ∈ {IDLE, DONE, HALT}; ignored when Busy.
  - Synchronous read, address issued in FETCH.
- IDLE/DONE/HALT + Start:
  - Latch Vec_Count; clear Error_Count, First_Err_*, Vector_Num, Done, Err_Halt.
  - Vec_Count=0 → DONE next cycle. Vec_Count>DEPTH → clamp to DEPTH.
  - Otherwise → FETCH.
- FETCH (1 cycle) → APPLY.
  - On the APPLY entry edge: Stim_Out ← stim[Vector_Num] and Stim_Valid=1.
  - Hold expected/mask in registers.
- APPLY: counts SETTLE cycles, then → CHECK.
- CHECK: mismatch = |((Observed ^ exp) & mask), using Observed sampled this cycle.
  - On mismatch: Error_Count += 1, saturating at all-ones. If First_Err_Valid=0, set it and capture First_Err_Idx.
  - Next state, in priority order:
    1. Vector_Num+1 == count → DONE.
    2. Stop_On_Err && mismatch → HALT (Err_Halt=1).
    3. Step_Mode → WAIT_STEP.
    4. Otherwise → FETCH.
  - Vector_Num increments except when going to DONE or HALT.
- Run-mode period: SETTLE+2 cycles per vector. Start at edge 0 → Stim_Out valid after edge 2 → first compare at edge 2+SETTLE.
- WAIT_STEP: Step → FETCH. Step in any other state is ignored.
- DONE/HALT:
  - Stim_Out and Stim_Valid hold the last vector, mirroring the testbench hold.
  - Busy=0; Done=1 in DONE only.
- Abort (any Busy state) → IDLE next edge. Stim_Valid=0; counters and First_Err_* are retained. Abort has priority over all other transitions.
- Start while Busy is ignored.
- Mask all-zeros: the vector never mismatches.
- Busy = state ∈ {FETCH, APPLY, CHECK, WAIT_STEP}.

Decomposition:
- Shared package: state enum encoding; default widths STIM_W_DEF=42 and EXP_W_DEF=8; function packing a vector entry as {stim, exp, mask}.
- One sub-module: tvs_vector_ram, a parametrised single-port synchronous RAM of width STIM_W+2*EXP_W and depth DEPTH. The FSM and compare logic stay in the top module.

Test Plan:
- Load 3 vectors: exp = 0x05, 0x0A, 0xFF, mask 0xFF. Observed follows stim[7:0] = 0x05, 0x0A, 0x00. Start with Vec_Count=3 and SETTLE=1 → Done after 9 cycles; Error_Count=1; First_Err_Idx=2; Stim_Out holds vector 2.
- Same vectors with Stop_On_Err=1 and vector 1 wrong → Err_Halt=1; Vector_Num=1; vector 2 is never applied; Error_Count=1.
- Step_Mode=1 with 2 vectors → FSM parks in WAIT_STEP after each CHECK. Done appears only after 1 Step pulse; Step pulses during APPLY have no effect.
- Mask 0xF0, exp 0x30, Observed 0x3F → no error. Vec_Count=0 → Done one cycle after Start, Stim_Valid stays 0.
- Assert Abort during APPLY of vector 1 → IDLE next edge; Busy=0; Error_Count retained. Load_En during the run leaves memory unchanged; a re-Start clears the counters.
- Assert Reset asynchronously mid-CHECK → all outputs 0 immediately. Force 2^ERRCNT_W+1 mismatches with a small ERRCNT_W=2 → Error_Count saturates at 3.
